// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: response and burst codes plus the responder FSM state types.
package axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } wr_state_t;

  typedef enum logic {
    RIdle,
    RData
  } rd_state_t;

endpackage

// File: rtl/axi_inf.sv
// AXI4 bus bundle; S is the slave-side view, M the master-side view.
interface AXI_INF #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     WR_ADDR_ID;
  logic [ADDR_WIDTH-1:0]   WR_ADDR;
  logic [7:0]              WR_ADDR_LEN;
  logic [1:0]              WR_ADDR_BURST;
  logic                    WR_ADDR_VALID;
  logic                    WR_ADDR_READY;
  logic [DATA_WIDTH-1:0]   WR_DATA;
  logic [DATA_WIDTH/8-1:0] WR_STRB;
  logic                    WR_DATA_LAST;
  logic                    WR_DATA_VALID;
  logic                    WR_DATA_READY;
  logic [ID_WIDTH-1:0]     WR_BACK_ID;
  logic [1:0]              WR_BACK_RESP;
  logic                    WR_BACK_VALID;
  logic                    WR_BACK_READY;
  logic [ID_WIDTH-1:0]     RD_ADDR_ID;
  logic [ADDR_WIDTH-1:0]   RD_ADDR;
  logic [7:0]              RD_ADDR_LEN;
  logic [1:0]              RD_ADDR_BURST;
  logic                    RD_ADDR_VALID;
  logic                    RD_ADDR_READY;
  logic [ID_WIDTH-1:0]     RD_DATA_ID;
  logic [DATA_WIDTH-1:0]   RD_DATA;
  logic [1:0]              RD_DATA_RESP;
  logic                    RD_DATA_LAST;
  logic                    RD_DATA_VALID;
  logic                    RD_DATA_READY;

  modport S (
    input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    output WR_ADDR_READY,
    input  WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID,
    output WR_DATA_READY,
    output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    input  WR_BACK_READY,
    input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    output RD_ADDR_READY,
    output RD_DATA_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    input  RD_DATA_READY
  );

  modport M (
    output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    input  WR_ADDR_READY,
    output WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID,
    input  WR_DATA_READY,
    input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    output WR_BACK_READY,
    output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    input  RD_ADDR_READY,
    input  RD_DATA_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    output RD_DATA_READY
  );

endinterface

// File: rtl/axi_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module axi_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/axi_slave_responder.sv
// Terminating AXI4 slave: sinks writes, returns fill data on reads, answers every burst with
// a fixed response and keeps debug counters of the stray accesses.
module axi_slave_responder
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [1:0]  RESP_CODE  = DECERR,
  parameter logic [63:0] RD_FILL    = 64'hDEADBEEF,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  AXI_INF.S                     AXI_S,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  wr_err_cnt,
  output logic [CNT_WIDTH-1:0]  rd_err_cnt,
  output logic [ADDR_WIDTH-1:0] last_err_addr,
  output logic                  len_mismatch
);

  localparam logic [DATA_WIDTH-1:0] FillData = DATA_WIDTH'(RD_FILL);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic                  ready_en_q;
  logic [ID_WIDTH-1:0]   wr_id_q, rd_id_q;
  logic [7:0]            wr_len_q, rd_len_q, rd_cnt_q;
  logic [8:0]            wr_cnt_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  len_mismatch_q;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = aw_ready & AXI_S.WR_ADDR_VALID;
  assign w_hs  = w_ready & AXI_S.WR_DATA_VALID;
  assign b_hs  = b_valid & AXI_S.WR_BACK_READY;
  assign ar_hs = ar_ready & AXI_S.RD_ADDR_VALID;
  assign r_hs  = r_valid & AXI_S.RD_DATA_READY;

  // ready_en_q keeps the idle READYs low while reset is (or has just been) asserted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= WIdle;
      rd_state_q <= RIdle;
      ready_en_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WIdle:   if (aw_hs) wr_state_d = WData;
      WData:   if (w_hs && AXI_S.WR_DATA_LAST) wr_state_d = WResp;
      WResp:   if (b_hs) wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RIdle:   if (ar_hs) rd_state_d = RData;
      RData:   if (r_hs && r_last) rd_state_d = RIdle;
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    unique case (wr_state_q)
      WIdle:   aw_ready = ready_en_q;
      WData:   w_ready  = 1'b1;
      WResp:   b_valid  = 1'b1;
      default: ;
    endcase
    unique case (rd_state_q)
      RIdle:   ar_ready = ready_en_q;
      RData:   r_valid  = 1'b1;
      default: ;
    endcase
    r_last = r_valid && (rd_cnt_q == rd_len_q);
  end

  // Write beat counter is one bit wider than LEN so a late WLAST cannot alias a match.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_id_q  <= '0;
      wr_len_q <= '0;
      wr_cnt_q <= '0;
      rd_id_q  <= '0;
      rd_len_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (aw_hs) begin
        wr_id_q  <= AXI_S.WR_ADDR_ID;
        wr_len_q <= AXI_S.WR_ADDR_LEN;
        wr_cnt_q <= '0;
      end else if (w_hs) begin
        wr_cnt_q <= wr_cnt_q + 9'd1;
      end
      if (ar_hs) begin
        rd_id_q  <= AXI_S.RD_ADDR_ID;
        rd_len_q <= AXI_S.RD_ADDR_LEN;
        rd_cnt_q <= '0;
      end else if (r_hs && !r_last) begin
        rd_cnt_q <= rd_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_addr_q    <= '0;
      len_mismatch_q <= 1'b0;
    end else if (cnt_clr) begin
      last_addr_q    <= '0;
      len_mismatch_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        last_addr_q <= AXI_S.WR_ADDR;
      end else if (ar_hs) begin
        last_addr_q <= AXI_S.RD_ADDR;
      end
      if (w_hs && AXI_S.WR_DATA_LAST && (wr_cnt_q != {1'b0, wr_len_q})) begin
        len_mismatch_q <= 1'b1;
      end
    end
  end

  axi_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (aw_hs),
    .clr  (cnt_clr),
    .q    (wr_err_cnt)
  );

  axi_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (ar_hs),
    .clr  (cnt_clr),
    .q    (rd_err_cnt)
  );

  assign AXI_S.WR_ADDR_READY = aw_ready;
  assign AXI_S.WR_DATA_READY = w_ready;
  assign AXI_S.WR_BACK_VALID = b_valid;
  assign AXI_S.WR_BACK_ID    = b_valid ? wr_id_q : '0;
  assign AXI_S.WR_BACK_RESP  = b_valid ? RESP_CODE : '0;
  assign AXI_S.RD_ADDR_READY = ar_ready;
  assign AXI_S.RD_DATA_VALID = r_valid;
  assign AXI_S.RD_DATA_ID    = r_valid ? rd_id_q : '0;
  assign AXI_S.RD_DATA       = r_valid ? FillData : '0;
  assign AXI_S.RD_DATA_RESP  = r_valid ? RESP_CODE : '0;
  assign AXI_S.RD_DATA_LAST  = r_last;

  assign last_err_addr = last_addr_q;
  assign len_mismatch  = len_mismatch_q;

  // Payload and burst type are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{AXI_S.WR_DATA, AXI_S.WR_STRB, AXI_S.WR_ADDR_BURST,
                           AXI_S.RD_ADDR_BURST};

endmodule

// File: tb/tb_axi_slave_responder.sv
// Directed-plus-random bench for axi_slave_responder against a transaction-level model.
module tb_axi_slave_responder;

  localparam int unsigned CW       = 3;
  localparam int          CNT_MAX  = (1 << CW) - 1;
  localparam logic [31:0] EXP_FILL = 32'hDEADBEEF;
  localparam logic [1:0]  EXP_RESP = 2'b11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] wr_err_cnt, rd_err_cnt;
  logic [31:0]   last_err_addr;
  logic          len_mismatch;

  AXI_INF #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_slave_responder #(
    .ID_WIDTH   (4),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESP_CODE  (2'b11),
    .RD_FILL    (64'hDEADBEEF),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .AXI_S         (bus),
    .cnt_clr       (cnt_clr),
    .wr_err_cnt    (wr_err_cnt),
    .rd_err_cnt    (rd_err_cnt),
    .last_err_addr (last_err_addr),
    .len_mismatch  (len_mismatch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model of the debug state.
  int          m_wr = 0;
  int          m_rd = 0;
  logic [31:0] m_addr = '0;
  logic        m_mism = 1'b0;

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "/wr_err_cnt"}, 64'(wr_err_cnt), 64'(sat(m_wr)));
    check({tag, "/rd_err_cnt"}, 64'(rd_err_cnt), 64'(sat(m_rd)));
    check({tag, "/last_err_addr"}, 64'(last_err_addr), 64'(m_addr));
    check({tag, "/len_mismatch"}, 64'(len_mismatch), 64'(m_mism));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/awready"}, bus.WR_ADDR_READY, 0);
    check({tag, "/wready"}, bus.WR_DATA_READY, 0);
    check({tag, "/bvalid"}, bus.WR_BACK_VALID, 0);
    check({tag, "/bid"}, bus.WR_BACK_ID, 0);
    check({tag, "/bresp"}, bus.WR_BACK_RESP, 0);
    check({tag, "/arready"}, bus.RD_ADDR_READY, 0);
    check({tag, "/rvalid"}, bus.RD_DATA_VALID, 0);
    check({tag, "/rdata"}, bus.RD_DATA, 0);
    check({tag, "/rlast"}, bus.RD_DATA_LAST, 0);
    check({tag, "/wr_err_cnt"}, wr_err_cnt, 0);
    check({tag, "/rd_err_cnt"}, rd_err_cnt, 0);
    check({tag, "/last_err_addr"}, last_err_addr, 0);
    check({tag, "/len_mismatch"}, len_mismatch, 0);
  endtask

  task automatic idle_bus();
    bus.WR_ADDR_ID = '0; bus.WR_ADDR = '0; bus.WR_ADDR_LEN = '0; bus.WR_ADDR_BURST = '0;
    bus.WR_ADDR_VALID = 1'b0;
    bus.WR_DATA = '0; bus.WR_STRB = '0; bus.WR_DATA_LAST = 1'b0; bus.WR_DATA_VALID = 1'b0;
    bus.WR_BACK_READY = 1'b0;
    bus.RD_ADDR_ID = '0; bus.RD_ADDR = '0; bus.RD_ADDR_LEN = '0; bus.RD_ADDR_BURST = '0;
    bus.RD_ADDR_VALID = 1'b0;
    bus.RD_DATA_READY = 1'b0;
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bus.RD_ADDR_ID = id; bus.RD_ADDR = addr; bus.RD_ADDR_LEN = len;
    bus.RD_ADDR_BURST = 2'($urandom_range(0, 2)); bus.RD_ADDR_VALID = 1'b1;
    for (int k = 0; k < 40 && bus.RD_ADDR_READY !== 1'b1; k++) cyc();
    check("arready_wait", bus.RD_ADDR_READY, 1);
    cyc();
    bus.RD_ADDR_VALID = 1'b0;
    m_rd++;
    m_addr = addr;
  endtask

  // Consumes a read burst; every cycle the visible beat must match the model's next beat.
  task automatic read_beats(input logic [3:0] id, input logic [7:0] len, input bit full);
    int beats = 0;
    int bound = 4 * (int'(len) + 1) + 20;
    logic rdy;
    for (int c = 0; c < bound && beats <= int'(len); c++) begin
      rdy = full ? 1'b1 : 1'($urandom_range(0, 1));
      bus.RD_DATA_READY = rdy;
      check("rvalid", bus.RD_DATA_VALID, 1);
      check("rdata", bus.RD_DATA, EXP_FILL);
      check("rid", bus.RD_DATA_ID, id);
      check("rresp", bus.RD_DATA_RESP, EXP_RESP);
      check("rlast", bus.RD_DATA_LAST, (beats == int'(len)));
      if (rdy && bus.RD_DATA_VALID === 1'b1) beats++;
      cyc();
    end
    bus.RD_DATA_READY = 1'b0;
    check("rbeats", 64'(beats), 64'(int'(len) + 1));
    check("arready_after_last", bus.RD_ADDR_READY, 1);
    check("rvalid_drop", bus.RD_DATA_VALID, 0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input bit full);
    ar_issue(id, addr, len);
    read_beats(id, len, full);
    check_regs("read");
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats, input int bwait, input bit gaps);
    bus.WR_ADDR_ID = id; bus.WR_ADDR = addr; bus.WR_ADDR_LEN = len;
    bus.WR_ADDR_BURST = 2'($urandom_range(0, 2)); bus.WR_ADDR_VALID = 1'b1;
    for (int k = 0; k < 40 && bus.WR_ADDR_READY !== 1'b1; k++) cyc();
    check("awready_wait", bus.WR_ADDR_READY, 1);
    cyc();
    bus.WR_ADDR_VALID = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
          bus.WR_DATA_VALID = 1'b0;
          check("wready_gap", bus.WR_DATA_READY, 1);
          cyc();
        end
      end
      bus.WR_DATA = $urandom; bus.WR_STRB = 4'hF;
      bus.WR_DATA_LAST = (b == nbeats - 1); bus.WR_DATA_VALID = 1'b1;
      check("wready", bus.WR_DATA_READY, 1);
      check("bvalid_early", bus.WR_BACK_VALID, 0);
      cyc();
    end
    bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0;
    for (int k = 0; k < bwait; k++) begin
      check("bvalid_hold", bus.WR_BACK_VALID, 1);
      check("bid_hold", bus.WR_BACK_ID, id);
      check("bresp_hold", bus.WR_BACK_RESP, EXP_RESP);
      cyc();
    end
    bus.WR_BACK_READY = 1'b1;
    check("bvalid", bus.WR_BACK_VALID, 1);
    check("bid", bus.WR_BACK_ID, id);
    check("bresp", bus.WR_BACK_RESP, EXP_RESP);
    cyc();
    bus.WR_BACK_READY = 1'b0;
    check("awready_after_b", bus.WR_ADDR_READY, 1);
    check("bvalid_drop", bus.WR_BACK_VALID, 0);
    m_wr++;
    m_addr = addr;
    if (nbeats - 1 != int'(len)) m_mism = 1'b1;
    check_regs("write");
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    m_wr = 0; m_rd = 0; m_addr = '0; m_mism = 1'b0;
    check_regs("clear");
  endtask

  initial begin
    idle_bus();
    // Reset state, including READYs held low.
    #12;
    check_all_zero("in_reset");
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    check("awready_out_of_reset", bus.WR_ADDR_READY, 1);
    check("arready_out_of_reset", bus.RD_ADDR_READY, 1);
    check_regs("post_reset");

    // W beats before AW must not be taken.
    bus.WR_DATA_VALID = 1'b1; bus.WR_DATA_LAST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("wready_in_idle", bus.WR_DATA_READY, 0);
      check("bvalid_in_idle", bus.WR_BACK_VALID, 0);
      cyc();
    end
    bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0;

    do_write(4'd3, 32'h1000, 8'd3, 4, 0, 1'b0);
    do_read(4'd5, 32'h2000, 8'd7, 1'b1);
    do_read(4'd9, 32'h2400, 8'd5, 1'b0);
    do_write(4'd6, 32'h1100, 8'd2, 3, 10, 1'b1);

    // Early WLAST, then sticky until cleared.
    do_write(4'd7, 32'h1200, 8'd3, 2, 0, 1'b0);
    do_write(4'd8, 32'h1300, 8'd0, 1, 1, 1'b0);
    // Late WLAST.
    do_write(4'd2, 32'h1400, 8'd1, 3, 0, 1'b0);
    clear_counters();

    // LEN boundaries.
    do_read(4'd1, 32'h2800, 8'd0, 1'b1);
    do_write(4'd4, 32'h1500, 8'd255, 256, 0, 1'b0);
    do_read(4'd12, 32'h2c00, 8'd255, 1'b1);

    // AW and AR in the same cycle: write address wins.
    clear_counters();
    bus.WR_ADDR_ID = 4'd1; bus.WR_ADDR = 32'hA000; bus.WR_ADDR_LEN = 8'd0;
    bus.WR_ADDR_VALID = 1'b1;
    bus.RD_ADDR_ID = 4'd2; bus.RD_ADDR = 32'hB000; bus.RD_ADDR_LEN = 8'd0;
    bus.RD_ADDR_VALID = 1'b1;
    check("dual_awready", bus.WR_ADDR_READY, 1);
    check("dual_arready", bus.RD_ADDR_READY, 1);
    cyc();
    bus.WR_ADDR_VALID = 1'b0; bus.RD_ADDR_VALID = 1'b0;
    m_wr = 1; m_rd = 1; m_addr = 32'hA000;
    check_regs("dual");
    bus.WR_DATA_VALID = 1'b1; bus.WR_DATA_LAST = 1'b1; bus.RD_DATA_READY = 1'b1;
    check("dual_wready", bus.WR_DATA_READY, 1);
    check("dual_rid", bus.RD_DATA_ID, 2);
    check("dual_rlast", bus.RD_DATA_LAST, 1);
    cyc();
    bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0; bus.RD_DATA_READY = 1'b0;
    bus.WR_BACK_READY = 1'b1;
    check("dual_bvalid", bus.WR_BACK_VALID, 1);
    check("dual_bid", bus.WR_BACK_ID, 1);
    cyc();
    bus.WR_BACK_READY = 1'b0;
    // Clear beats a simultaneous AR increment and address capture.
    bus.RD_ADDR_ID = 4'd4; bus.RD_ADDR = 32'hC000; bus.RD_ADDR_LEN = 8'd0;
    bus.RD_ADDR_VALID = 1'b1;
    check("clr_arready", bus.RD_ADDR_READY, 1);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0; bus.RD_ADDR_VALID = 1'b0;
    m_wr = 0; m_rd = 0; m_addr = '0; m_mism = 1'b0;
    check_regs("clr_with_ar");
    read_beats(4'd4, 8'd0, 1'b1);

    // Saturation of the narrow counters.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      do_write(4'(i), 32'h4000 + 32'(i * 16), 8'd0, 1, 0, 1'b0);
    end

    // Randomised mix of bursts with back-pressure.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] len = 8'($urandom_range(0, 7));
      logic [3:0] id = 4'($urandom_range(0, 15));
      logic [31:0] addr = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(0, 1) == 1) begin
        do_read(id, addr, len, 1'($urandom_range(0, 1)));
      end else begin
        do_write(id, addr, len, int'(len) + 1, int'($urandom_range(0, 4)), 1'b1);
      end
    end

    // Reset in the middle of a 16-beat read.
    ar_issue(4'd10, 32'h3000, 8'd15);
    bus.RD_DATA_READY = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("mid_burst_reset");
    bus.RD_DATA_READY = 1'b0;
    m_wr = 0; m_rd = 0; m_addr = '0; m_mism = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    check("rvalid_after_release", bus.RD_DATA_VALID, 0);
    check("arready_after_release", bus.RD_ADDR_READY, 1);
    do_read(4'd11, 32'h3100, 8'd6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
